// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer
// Posted-write buffer between the CPU memory-access stage and a single-port
// data memory. Stores retire into a FIFO in one cycle and drain to memory
// whenever the port is not taken by a load. Loads read memory combinationally,
// with forwarding from the youngest matching buffered store. A fence holds the
// CPU until the buffer is empty. A starvation guard forces a drain after
// STARVE_LIMIT consecutive load-blocked cycles.
//
// Ports:
//   clk, reset   clock; synchronous active-high reset
//   cpu_addr     word address of load/store
//   cpu_data     store data
//   cpu_we       store request (wins over cpu_re)
//   cpu_re       load request
//   cpu_fence    hold the CPU until the buffer is empty
//   cpu_q        load data, same cycle
//   cpu_stall    request not accepted; CPU holds it
//   mem_addr     memory address
//   mem_data     memory write data
//   mem_we       memory write enable
//   mem_q        memory read data for mem_addr (combinational)
module dmem_store_buffer #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_data,
  input  logic        cpu_we,
  input  logic        cpu_re,
  input  logic        cpu_fence,
  output logic [31:0] cpu_q,
  output logic        cpu_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_we,
  input  logic [31:0] mem_q
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);

  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];

  logic             nonempty_s, full_s, fence_blk_s, force_s;
  logic             load_req_s, load_acc_s, store_acc_s, drain_s;
  logic             fwd_hit_s;
  logic [31:0]      fwd_data_s;
  logic [PTR_W-1:0] fwd_idx_s;

  // Request arbitration: fence first, then starvation guard, then load vs drain.
  always_comb begin
    nonempty_s  = (count_q != {CNT_W{1'b0}});
    full_s      = (count_q == CNT_W'(DEPTH));
    fence_blk_s = cpu_fence && nonempty_s;
    force_s     = nonempty_s && (starve_q == SW'(STARVE_LIMIT));
    load_req_s  = cpu_re && !cpu_we;
    load_acc_s  = load_req_s && !fence_blk_s && !force_s;
    store_acc_s = cpu_we && !fence_blk_s && !full_s;
    drain_s     = nonempty_s && !load_acc_s;
  end

  // Forwarding: walk from head to tail so a later (younger) match overrides.
  always_comb begin
    fwd_hit_s  = 1'b0;
    fwd_data_s = 32'h0000_0000;
    fwd_idx_s  = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx_s = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_q[fwd_idx_s] == cpu_addr)) begin
        fwd_hit_s  = 1'b1;
        fwd_data_s = data_q[fwd_idx_s];
      end else begin
        fwd_hit_s  = fwd_hit_s;
      end
    end
  end

  // Memory port and CPU-facing outputs; everything quiet while in reset.
  always_comb begin
    if (reset) begin
      mem_we    = 1'b0;
      mem_addr  = cpu_addr;
      mem_data  = cpu_data;
      cpu_stall = 1'b0;
      cpu_q     = 32'h0000_0000;
    end else begin
      mem_we    = drain_s;
      mem_addr  = drain_s ? addr_q[head_q] : cpu_addr;
      mem_data  = drain_s ? data_q[head_q] : cpu_data;
      cpu_stall = fence_blk_s || (cpu_we && full_s) || (load_req_s && force_s);
      cpu_q     = fwd_hit_s ? fwd_data_s : mem_q;
    end
  end

  // Next-state for occupancy and the starvation counter.
  always_comb begin
    case ({store_acc_s, drain_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (drain_s || !nonempty_s) begin
      starve_d = {SW{1'b0}};
    end else if (load_acc_s) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Pointer, count and starvation state.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q   <= {PTR_W{1'b0}};
      tail_q   <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      starve_q <= {SW{1'b0}};
    end else begin
      if (store_acc_s) tail_q <= tail_q + PTR_W'(1);
      if (drain_s)     head_q <= head_q + PTR_W'(1);
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  // Entry storage; contents are don't-care until counted as valid.
  always_ff @(posedge clk) begin
    if (store_acc_s && !reset) begin
      addr_q[tail_q] <= cpu_addr;
      data_q[tail_q] <= cpu_data;
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
module tb_dmem_store_buffer;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_data;
  logic        cpu_we, cpu_re, cpu_fence;
  logic [31:0] cpu_q;
  logic        cpu_stall;
  logic [31:0] mem_addr, mem_data;
  logic        mem_we;
  logic [31:0] mem_q;

  logic [31:0] tb_mem [256];

  dmem_store_buffer #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_fence(cpu_fence),
    .cpu_q(cpu_q), .cpu_stall(cpu_stall),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  // Behavioural data memory: combinational read, write on rising edge.
  assign mem_q = tb_mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr[7:0]] <= mem_data;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pending stores in program order; each DUT write pops the head.
  typedef struct { logic [31:0] addr; logic [31:0] data; } st_t;
  st_t sb_q[$];
  int  m_starve = 0;
  logic exp_stall_r = 1'b0;

  // One clock cycle: drive after the edge, check and update model mid-cycle.
  task automatic cyc(input logic we, input logic re, input logic fence,
                     input logic [31:0] addr, input logic [31:0] data,
                     input logic rst);
    int   cnt;
    logic fence_blk, force_d, ld, ld_acc, st_acc, exp_drain, hit;
    logic [31:0] exp_q;
    st_t  e;
    @(posedge clk); #1;
    reset = rst; cpu_we = we; cpu_re = re; cpu_fence = fence;
    cpu_addr = addr; cpu_data = data;
    @(negedge clk);
    if (rst) begin
      check_eq("rst_stall", {31'd0, cpu_stall}, 32'd0);
      check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
      sb_q.delete();
      m_starve = 0;
      exp_stall_r = 1'b0;
      return;
    end
    cnt       = sb_q.size();
    fence_blk = fence && (cnt > 0);
    force_d   = (cnt > 0) && (m_starve == STARVE_LIMIT);
    ld        = re && !we;
    ld_acc    = ld && !fence_blk && !force_d;
    st_acc    = we && !fence_blk && (cnt < DEPTH);
    exp_drain = (cnt > 0) && !ld_acc;
    exp_stall_r = fence_blk || (we && cnt >= DEPTH) || (ld && force_d);
    check_eq("stall", {31'd0, cpu_stall}, {31'd0, exp_stall_r});
    check_eq("mem_we", {31'd0, mem_we}, {31'd0, exp_drain});
    if (exp_drain) begin
      e = sb_q.pop_front();
      check_eq("drain_addr", mem_addr, e.addr);
      check_eq("drain_data", mem_data, e.data);
    end else begin
      check_eq("port_addr", mem_addr, addr);
    end
    if (ld_acc) begin
      hit = 1'b0;
      exp_q = tb_mem[addr[7:0]];
      foreach (sb_q[i]) if (sb_q[i].addr == addr) begin hit = 1'b1; exp_q = sb_q[i].data; end
      check_eq("load_q", cpu_q, exp_q);
    end
    if (st_acc) sb_q.push_back('{addr: addr, data: data});
    if (exp_drain || cnt == 0) m_starve = 0;
    else if (ld_acc) m_starve++;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0, 1'b0);
  endtask
  task automatic st(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b0, 1'b0, a, d, 1'b0);
  endtask
  task automatic ld(input logic [31:0] a);
    cyc(1'b0, 1'b1, 1'b0, a, 32'h0, 1'b0);
  endtask

  initial begin
    int stall_at, n_stalls;
    logic w, r, f;
    logic [31:0] a, d;
    for (int i = 0; i < 256; i++) tb_mem[i] = 32'hF000_0000 | i;
    reset = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0; cpu_fence = 1'b0;
    cpu_addr = 32'h0; cpu_data = 32'h0;

    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    idle();

    // In-order stores, first drain overlaps the second store
    st(32'h10, 32'h11); st(32'h11, 32'h22); st(32'h12, 32'h33);
    idle(); idle();
    check_eq("mem_10", tb_mem[8'h10], 32'h11);
    check_eq("mem_11", tb_mem[8'h11], 32'h22);
    check_eq("mem_12", tb_mem[8'h12], 32'h33);

    // Youngest-match forwarding ahead of a stale memory copy
    st(32'h20, 32'hAAAA); st(32'h20, 32'hBBBB);
    ld(32'h20);
    check_eq("fwd_young", cpu_q, 32'hBBBB);
    ld(32'h21);
    check_eq("miss_mem", cpu_q, 32'hF000_0021);
    idle(); idle();

    // Starvation guard: one buffered entry, 20 back-to-back loads
    st(32'h30, 32'h3030);
    stall_at = 0; n_stalls = 0;
    for (int k = 1; k <= 20; k++) begin
      ld(32'h50);
      if (exp_stall_r) begin n_stalls++; if (stall_at == 0) stall_at = k; end
    end
    check_eq("starve_cycle", stall_at, 32'd9);
    check_eq("starve_count", n_stalls, 32'd1);
    check_eq("mem_30", tb_mem[8'h30], 32'h3030);

    // Fence with a pending entry stalls a concurrent store until empty
    st(32'h40, 32'h4040);
    n_stalls = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b0, 1'b1, 32'h41, 32'h4141, 1'b0);
      if (exp_stall_r) n_stalls++;
      else break;
    end
    check_eq("fence_stalls", n_stalls, 32'd1);
    idle(); idle();
    check_eq("mem_41", tb_mem[8'h41], 32'h4141);

    // Reset with a store still buffered discards it
    st(32'h60, 32'h6666);
    ld(32'h70);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    idle(); idle();
    ld(32'h60);
    check_eq("rst_discard", cpu_q, 32'hF000_0060);

    // Mixed random traffic, holding any stalled request
    w = 1'b0; r = 1'b0; f = 1'b0; a = 32'h0; d = 32'h0;
    for (int k = 0; k < 400; k++) begin
      if (!exp_stall_r) begin
        w = ($urandom_range(0, 2) == 0);
        r = ($urandom_range(0, 1) == 0);
        f = ($urandom_range(0, 9) == 0);
        a = 32'h80 + $urandom_range(0, 3);
        d = $urandom;
      end
      cyc(w, r, f, a, d, 1'b0);
    end
    for (int k = 0; k < 3; k++) idle();
    check_eq("sb_empty", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
